// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Purpose  : Instruction-decode stage of the 19-bit pipeline. Decodes the
//            fetched instruction, reads an 8 x 19-bit register file with
//            write-through, detects load-use hazards and absolute jumps, and
//            registers the result into the ID/EX pipeline register.
// Ports    : clk, reset (async, active-high)
//            if_instr/if_pc           - fetch-stage instruction and PC+1
//            flush                    - discard incoming instruction
//            ex_mem_read/ex_rd        - load currently in EX (hazard check)
//            wb_we/wb_rd/wb_data      - register-file write port
//            stall_out                - combinational fetch hold request
//            jump_valid/jump_target   - registered fetch redirect
//            id_*                     - ID/EX pipeline register contents
// Revision : 1.0 - initial release
// ============================================================================
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] if_instr,
  input  logic [13:0] if_pc,
  input  logic        flush,
  input  logic        ex_mem_read,
  input  logic [2:0]  ex_rd,
  input  logic        wb_we,
  input  logic [2:0]  wb_rd,
  input  logic [18:0] wb_data,
  output logic        stall_out,
  output logic        jump_valid,
  output logic [13:0] jump_target,
  output logic        id_valid,
  output logic [13:0] id_pc,
  output logic [2:0]  id_alu_op,
  output logic [18:0] id_rs1_data,
  output logic [18:0] id_rs2_data,
  output logic [18:0] id_imm,
  output logic [2:0]  id_rd,
  output logic [2:0]  id_rs1,
  output logic [2:0]  id_rs2,
  output logic        id_reg_write,
  output logic        id_mem_read,
  output logic        id_mem_write,
  output logic        id_use_imm,
  output logic        id_illegal
);

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_LD   = 5'b01001;
  localparam logic [4:0] OP_ST   = 5'b01010;
  localparam logic [4:0] OP_JMP  = 5'b01011;

  logic [4:0]  opcode;
  logic [2:0]  f_rd;
  logic [2:0]  f_rs1;
  logic [2:0]  f_rs2;

  assign opcode = if_instr[18:14];
  assign f_rd   = if_instr[13:11];
  assign f_rs1  = if_instr[10:8];
  assign f_rs2  = if_instr[7:5];

  // Decoded controls
  logic [2:0]  dec_alu_op;
  logic [2:0]  dec_rd;
  logic [2:0]  dec_rs2;
  logic        dec_reg_write;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_use_imm;
  logic        dec_illegal;
  logic        dec_jmp;
  logic        dec_uses_rs2;

  always_comb begin
    dec_alu_op    = 3'b000;
    dec_rd        = f_rd;
    dec_rs2       = f_rs2;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_use_imm   = 1'b0;
    dec_illegal   = 1'b0;
    dec_jmp       = 1'b0;
    dec_uses_rs2  = 1'b0;
    casez (opcode)
      OP_NOP: ;
      5'b00???: begin
        // R-type: opcodes 1..7, NOP already matched above
        dec_alu_op    = opcode[2:0];
        dec_reg_write = 1'b1;
        dec_uses_rs2  = 1'b1;
      end
      OP_ADDI: begin
        dec_alu_op    = 3'b001;
        dec_use_imm   = 1'b1;
        dec_reg_write = 1'b1;
      end
      OP_LD: begin
        dec_alu_op    = 3'b001;
        dec_use_imm   = 1'b1;
        dec_mem_read  = 1'b1;
        dec_reg_write = 1'b1;
      end
      OP_ST: begin
        // Store data register is named by the rd field; a store writes no register
        dec_alu_op    = 3'b001;
        dec_use_imm   = 1'b1;
        dec_mem_write = 1'b1;
        dec_rs2       = f_rd;
        dec_rd        = 3'b000;
        dec_uses_rs2  = 1'b1;
      end
      OP_JMP:  dec_jmp = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

  // Register file; entry 0 is never written and always reads as zero
  logic [18:0] regs [0:7];
  logic [18:0] rs1_data;
  logic [18:0] rs2_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (wb_we && (wb_rd != 3'd0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Write-through so a same-cycle writeback is seen without a forwarding path
  assign rs1_data = (f_rs1 == 3'd0) ? '0 :
                    (wb_we && (wb_rd == f_rs1)) ? wb_data : regs[f_rs1];
  assign rs2_data = (dec_rs2 == 3'd0) ? '0 :
                    (wb_we && (wb_rd == dec_rs2)) ? wb_data : regs[dec_rs2];

  // Load-use hazard; a registered jump marks the incoming instruction as squashed
  logic hazard;
  logic squash;

  assign squash    = jump_valid;
  assign hazard    = ex_mem_read && (ex_rd != 3'd0) &&
                     ((ex_rd == f_rs1) || (dec_uses_rs2 && (ex_rd == dec_rs2)));
  assign stall_out = hazard && !flush && !squash;

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jump_valid   <= 1'b0;
      jump_target  <= '0;
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_alu_op    <= '0;
      id_rs1_data  <= '0;
      id_rs2_data  <= '0;
      id_imm       <= '0;
      id_rd        <= '0;
      id_rs1       <= '0;
      id_rs2       <= '0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
      id_use_imm   <= 1'b0;
      id_illegal   <= 1'b0;
    end else if (flush || squash || hazard) begin
      // Bubble; jump_target keeps its last value, it is only meaningful with jump_valid
      jump_valid   <= 1'b0;
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_alu_op    <= '0;
      id_rs1_data  <= '0;
      id_rs2_data  <= '0;
      id_imm       <= '0;
      id_rd        <= '0;
      id_rs1       <= '0;
      id_rs2       <= '0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
      id_use_imm   <= 1'b0;
      id_illegal   <= 1'b0;
    end else begin
      jump_valid   <= dec_jmp;
      jump_target  <= if_instr[13:0];
      id_valid     <= 1'b1;
      id_pc        <= if_pc;
      id_alu_op    <= dec_alu_op;
      id_rs1_data  <= rs1_data;
      id_rs2_data  <= rs2_data;
      id_imm       <= {{11{if_instr[7]}}, if_instr[7:0]};
      id_rd        <= dec_rd;
      id_rs1       <= f_rs1;
      id_rs2       <= dec_rs2;
      id_reg_write <= dec_reg_write;
      id_mem_read  <= dec_mem_read;
      id_mem_write <= dec_mem_write;
      id_use_imm   <= dec_use_imm;
      id_illegal   <= dec_illegal;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Purpose  : Self-checking bench for id_stage. A driver applies directed and
//            random instructions, a reference model pushes the expected ID/EX
//            contents and stall_out into queues, and monitors pop and compare.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] if_instr;
  logic [13:0] if_pc;
  logic        flush;
  logic        ex_mem_read;
  logic [2:0]  ex_rd;
  logic        wb_we;
  logic [2:0]  wb_rd;
  logic [18:0] wb_data;
  logic        stall_out;
  logic        jump_valid;
  logic [13:0] jump_target;
  logic        id_valid;
  logic [13:0] id_pc;
  logic [2:0]  id_alu_op;
  logic [18:0] id_rs1_data;
  logic [18:0] id_rs2_data;
  logic [18:0] id_imm;
  logic [2:0]  id_rd;
  logic [2:0]  id_rs1;
  logic [2:0]  id_rs2;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_use_imm;
  logic        id_illegal;

  id_stage dut (
    .clk(clk), .reset(reset), .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .stall_out(stall_out), .jump_valid(jump_valid),
    .jump_target(jump_target), .id_valid(id_valid), .id_pc(id_pc),
    .id_alu_op(id_alu_op), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_use_imm(id_use_imm), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [13:0] pc;
    logic [2:0]  alu;
    logic [18:0] d1;
    logic [18:0] d2;
    logic [18:0] imm;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ui;
    logic        ill;
    logic        jv;
    logic [13:0] jt;
  } exp_t;

  exp_t q[$];
  logic sq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference architectural state
  logic [18:0] m_regs [8];
  logic        m_jv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [18:0] m_read(input logic [2:0] a, input logic we,
                                         input logic [2:0] wrd, input logic [18:0] wd);
    if (a == 3'd0) return 19'd0;
    if (we && wrd == a) return wd;
    return m_regs[a];
  endfunction

  // Apply one cycle of stimulus (called at a falling edge) and predict the result
  task automatic step(input logic [18:0] instr, input logic [13:0] pc, input logic fl,
                      input logic emr, input logic [2:0] erd, input logic we,
                      input logic [2:0] wrd, input logic [18:0] wd, output logic stalled);
    int          op;
    logic [2:0]  rs1a, rs2a;
    logic        uses2, haz;
    exp_t        e;
    if_instr = instr; if_pc = pc; flush = fl; ex_mem_read = emr; ex_rd = erd;
    wb_we = we; wb_rd = wrd; wb_data = wd;
    op    = int'(instr[18:14]);
    rs1a  = instr[10:8];
    rs2a  = (op == 10) ? instr[13:11] : instr[7:5];
    uses2 = (op >= 1 && op <= 7) || op == 10;
    haz   = emr && erd != 0 && (erd == rs1a || (uses2 && erd == rs2a));
    stalled = haz && !fl && !m_jv;
    sq.push_back(stalled);
    e = '0;
    if (!(fl || m_jv || haz)) begin
      e.valid = 1'b1;
      e.pc    = pc;
      e.rs1   = rs1a;
      e.rs2   = rs2a;
      e.rd    = (op == 10) ? 3'd0 : instr[13:11];
      e.d1    = m_read(rs1a, we, wrd, wd);
      e.d2    = m_read(rs2a, we, wrd, wd);
      e.imm   = 19'($signed(instr[7:0]));
      e.jt    = instr[13:0];
      if (op >= 1 && op <= 7) begin
        e.alu = 3'(op);
        e.rw  = 1'b1;
      end else begin
        case (op)
          0:  ;
          8:  begin e.alu = 3'd1; e.ui = 1'b1; e.rw = 1'b1; end
          9:  begin e.alu = 3'd1; e.ui = 1'b1; e.rw = 1'b1; e.mr = 1'b1; end
          10: begin e.alu = 3'd1; e.ui = 1'b1; e.mw = 1'b1; end
          11: e.jv = 1'b1;
          default: e.ill = 1'b1;
        endcase
      end
    end
    q.push_back(e);
    m_jv = e.jv;
    if (we && wrd != 0) m_regs[wrd] = wd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; ex_mem_read = 1'b0; ex_rd = 3'd0;
    wb_we = 1'b0; wb_rd = 3'd0; wb_data = '0;
    #1;
    chk("rst_jump_valid", jump_valid, 0);
    chk("rst_jump_target", jump_target, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_rd", id_rd, 0);
    chk("rst_id_rs1_data", id_rs1_data, 0);
    chk("rst_id_imm", id_imm, 0);
    chk("rst_id_ctrl", {id_reg_write, id_mem_read, id_mem_write, id_use_imm, id_illegal}, 0);
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_jv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Registered-output monitor
  initial begin : mon
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("id_valid", id_valid, e.valid);
        chk("id_pc", id_pc, e.pc);
        chk("id_alu_op", id_alu_op, e.alu);
        chk("id_rs1_data", id_rs1_data, e.d1);
        chk("id_rs2_data", id_rs2_data, e.d2);
        chk("id_imm", id_imm, e.imm);
        chk("id_rd", id_rd, e.rd);
        chk("id_rs1", id_rs1, e.rs1);
        chk("id_rs2", id_rs2, e.rs2);
        chk("id_reg_write", id_reg_write, e.rw);
        chk("id_mem_read", id_mem_read, e.mr);
        chk("id_mem_write", id_mem_write, e.mw);
        chk("id_use_imm", id_use_imm, e.ui);
        chk("id_illegal", id_illegal, e.ill);
        chk("jump_valid", jump_valid, e.jv);
        if (e.jv) chk("jump_target", jump_target, e.jt);
      end
    end
  end

  // Combinational stall monitor, sampled after the driver has settled inputs
  initial begin : smon
    forever begin
      @(negedge clk);
      #2;
      if (sq.size() > 0) chk("stall_out", stall_out, sq.pop_front());
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : drv
    logic        st;
    logic [18:0] instr;
    logic [13:0] pc;
    logic        held;
    int          r;
    if_instr = '0; if_pc = '0;
    do_reset();

    // Decode with register read and sign-extended immediate
    step(19'd0, 14'd1, 0, 0, 3'd0, 1, 3'd3, 19'h00005, st);
    step(19'b01000_010_011_11111111, 14'd2, 0, 0, 3'd0, 0, 3'd0, 19'd0, st);
    // Write-through on rs1, r0 on rs2
    step({5'b00001, 3'd1, 3'd4, 3'd0, 5'd0}, 14'd3, 0, 0, 3'd0, 1, 3'd4, 19'h12345, st);
    // r0 ignores writes
    step({5'b00010, 3'd5, 3'd0, 3'd0, 5'd0}, 14'd4, 0, 0, 3'd0, 1, 3'd0, 19'h7FFFF, st);
    step({5'b00011, 3'd5, 3'd0, 3'd4, 5'd0}, 14'd5, 0, 0, 3'd0, 0, 3'd0, 19'd0, st);
    // Load-use on ST data register, then the load leaves EX
    step({5'b01010, 3'd2, 3'd1, 8'h05}, 14'd6, 0, 1, 3'd2, 0, 3'd0, 19'd0, st);
    step({5'b01010, 3'd2, 3'd1, 8'h05}, 14'd6, 0, 0, 3'd2, 0, 3'd0, 19'd0, st);
    // ex_rd = 0 never stalls
    step({5'b01001, 3'd0, 3'd0, 8'h80}, 14'd7, 0, 1, 3'd0, 0, 3'd0, 19'd0, st);
    // JMP followed by ADDI (squashed)
    step({5'b01011, 14'h1ABC}, 14'd8, 0, 0, 3'd0, 0, 3'd0, 19'd0, st);
    step(19'b01000_010_011_00000011, 14'd9, 0, 0, 3'd0, 0, 3'd0, 19'd0, st);
    step(19'd0, 14'd10, 0, 0, 3'd0, 0, 3'd0, 19'd0, st);
    // Back-to-back JMPs
    step({5'b01011, 14'h0111}, 14'd11, 0, 0, 3'd0, 0, 3'd0, 19'd0, st);
    step({5'b01011, 14'h0222}, 14'd12, 0, 0, 3'd0, 0, 3'd0, 19'd0, st);
    step(19'd0, 14'd13, 0, 0, 3'd0, 0, 3'd0, 19'd0, st);
    // Flush beats stall; writeback still happens
    step({5'b00001, 3'd1, 3'd2, 3'd3, 5'd0}, 14'd14, 1, 1, 3'd2, 1, 3'd6, 19'h0ABCD, st);
    step({5'b00001, 3'd1, 3'd6, 3'd3, 5'd0}, 14'd15, 0, 0, 3'd0, 0, 3'd0, 19'd0, st);
    // Illegal opcode
    step({5'b11111, 14'h0123}, 14'd16, 0, 0, 3'd0, 0, 3'd0, 19'd0, st);
    // Reset while jump_valid is high
    step({5'b01011, 14'h2345}, 14'd17, 0, 0, 3'd0, 0, 3'd0, 19'd0, st);
    do_reset();
    step({5'b00001, 3'd1, 3'd3, 3'd4, 5'd0}, 14'd18, 0, 0, 3'd0, 0, 3'd0, 19'd0, st);
    step({5'b00001, 3'd1, 3'd6, 3'd2, 5'd0}, 14'd19, 0, 0, 3'd0, 0, 3'd0, 19'd0, st);

    // Randomized traffic; fetch holds its instruction while stalled
    held = 1'b0; instr = '0; pc = '0;
    for (int n = 0; n < 1500; n++) begin
      if (n % 500 == 499) begin
        do_reset();
        held = 1'b0;
      end
      if (!held) begin
        r = $urandom_range(0, 9);
        instr = 19'($urandom);
        case (r)
          0:       instr[18:14] = 5'd0;
          1, 2, 3: instr[18:14] = 5'($urandom_range(1, 7));
          4:       instr[18:14] = 5'd8;
          5:       instr[18:14] = 5'd9;
          6:       instr[18:14] = 5'd10;
          7:       instr[18:14] = 5'd11;
          default: instr[18:14] = 5'($urandom);
        endcase
        pc = 14'($urandom);
      end
      step(instr, pc, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
           3'($urandom), 1'($urandom), 3'($urandom), 19'($urandom), st);
      held = st;
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 19-bit pipeline. It sits directly downstream of the fetch stage and consumes its registered 19-bit instruction and 14-bit incremented PC. It decodes fields, reads an internal 8 × 19-bit register file, and detects load-use hazards and absolute jumps. It registers everything into the ID/EX pipeline register.

## Interface

No parameters.

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- if_instr  in  19  instruction from fetch stage
- if_pc  in  14  PC+1 from fetch stage
- flush  in  1  EX-resolved branch taken; discard incoming instruction
- ex_mem_read  in  1  instruction currently in EX is a load
- ex_rd  in  3  destination register of instruction in EX
- wb_we  in  1  writeback enable
- wb_rd  in  3  writeback register
- wb_data  in  19  writeback value
- stall_out  out  1  combinational; upstream PC/fetch must hold while high
- jump_valid  out  1  registered; redirect fetch to jump_target
- jump_target  out  14  absolute jump address
- id_valid  out  1  ID/EX slot holds a real instruction
- id_pc  out  14  PC+1 of latched instruction
- id_alu_op  out  3  ALU function
- id_rs1_data, id_rs2_data  out  19 each  operand values
- id_imm  out  19  sign-extended immediate
- id_rd, id_rs1, id_rs2  out  3 each  register addresses
- id_reg_write, id_mem_read, id_mem_write, id_use_imm, id_illegal  out  1 each  control

## Operation

- Fields: opcode [18:14], rd [13:11], rs1 [10:8], rs2 [7:5], imm8 [7:0], addr14 [13:0].
- Opcodes:
  - 00000 NOP.
  - 00001–00111 R-type ALU: alu_op = opcode[2:0], reg_write = 1.
  - 01000 ADDI: alu_op = 001, use_imm = 1, reg_write = 1.
  - 01001 LD: alu_op = 001, use_imm = 1, mem_read = 1, reg_write = 1.
  - 01010 ST: alu_op = 001, use_imm = 1, mem_write = 1. The rs2 address is taken from the rd field; id_rd = 0.
  - 01011 JMP: no register effects.
  - Every other opcode is decoded as a NOP with id_illegal = 1.
- imm = sign-extend imm8 to 19 bits (bit 7 replicated into bits 18:8).
- Register file:
  - r0 reads 0 and ignores writes.
  - Written on the rising edge when wb_we = 1 and wb_rd ≠ 0.
  - Read is write-through: if wb_we = 1, wb_rd ≠ 0 and wb_rd equals the read address, the read returns wb_data in the same cycle.
- Load-use hazard: stall_out = ex_mem_read & (ex_rd ≠ 0) & (ex_rd == rs1, or ex_rd == the rs2 address when the opcode uses rs2). Opcodes that use rs2 are R-type and ST. stall_out is forced to 0 when flush = 1 or squash = 1.
- squash is an internal flag equal to jump_valid. It marks the incoming instruction as wrong-path.
- Next-state priority at each edge: flush > squash > stall > normal.
  - flush, squash or stall: load a bubble (id_valid = 0, all control outputs 0, ids 0, data 0), and jump_valid ← 0.
  - normal: latch the decoded instruction with id_valid = 1. jump_valid ← 1 if the opcode is JMP, else 0. jump_target ← addr14.
- A JMP travels down the pipeline as id_valid = 1 with all write controls 0.

## Timing

- Reset (asynchronous):
  - Every output register clears to 0: id_*, jump_valid, jump_target.
  - All eight registers clear to 0.
  - stall_out follows its combinational equation.
- Decode latency: one cycle; instruction present on if_instr before edge N appears on id_* after edge N.
- Jump timing:
  - JMP latched at edge N; jump_valid is high for exactly one cycle, until edge N+1.
  - The instruction arriving in that cycle is replaced by a bubble at edge N+1.
  - Back-to-back JMP: the second JMP is the squashed one and produces no redirect.
- Stall: while stall_out = 1, upstream must hold if_instr/if_pc. Each stalled cycle inserts one bubble. In normal flow the stall lasts one cycle, because the load advances out of EX.
- If flush and wb_we occur in the same cycle, the register write still happens.
- If reset is asserted mid-stall or mid-jump, all state clears immediately and no redirect is issued after reset.

## Test plan

- Reset and decode:
  - Assert reset, then check all id_* = 0 and jump_valid = 0.
  - Write r3 = 0x00005, then feed ADDI r2, r3, 0xFF (19'b01000_010_011_11111111).
  - Expect id_rs1_data = 5, id_imm = 0x7FFFF, id_reg_write = 1, id_use_imm = 1.
- Write-through and r0:
  - Same cycle: wb_we = 1, wb_rd = 4, wb_data = 0x12345, and R-type rs1 = 4, rs2 = 0.
  - Expect id_rs1_data = 0x12345 and id_rs2_data = 0.
  - Write r0 = 0x7FFFF, read r0 → 0.
- Load-use:
  - ex_mem_read = 1, ex_rd = 2, incoming ST with rd field = 2 → stall_out = 1 and a bubble is latched next edge.
  - With ex_rd = 0 → no stall.
- Jump:
  - Feed JMP 0x1ABC followed by ADDI → jump_valid = 1 for one cycle, jump_target = 0x1ABC, and the ADDI becomes a bubble (id_valid = 0).
  - Back-to-back JMPs → only the first redirects.
- Priority:
  - flush = 1 together with a stall condition and a valid ADD → bubble latched and stall_out = 0.
  - Illegal opcode 11111 → id_illegal = 1, id_valid = 1, no write controls.
- Mid-operation reset:
  - Assert reset while jump_valid = 1 → jump_valid = 0 immediately, and all registers read 0 afterwards.
